// File: rtl/event_encoder_8_3_pkg.sv
// Shared widths and FSM encoding for the event encoder path.
package event_encoder_8_3_pkg;
    localparam int IN_DEF  = 8;
    localparam int OUT_DEF = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;
endpackage

// File: rtl/event_encoder_8_3_pri_enc.sv
// Highest-index-wins priority encoder with an any-bit-set flag.
module pri_enc_8_3
    import event_encoder_8_3_pkg::*;
#(
    parameter int IN  = IN_DEF,
    parameter int OUT = OUT_DEF
) (
    input  logic [IN-1:0]  vec,
    output logic [OUT-1:0] idx,
    output logic           any
);
    always_comb begin
        idx = '0;
        any = |vec;
        // Ascending scan so the last (highest) set bit overwrites lower ones.
        for (int i = 0; i < IN; i++) begin
            if (vec[i]) idx = OUT'(i);
        end
    end
endmodule

// File: rtl/event_encoder_8_3.sv
// Latches multi-hot events into a pending register and hands them out as
// indices, highest first, one per valid/ready handshake.
module event_encoder_8_3
    import event_encoder_8_3_pkg::*;
#(
    parameter int IN  = IN_DEF,
    parameter int OUT = OUT_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic [IN-1:0]  in,
    output logic [OUT-1:0] out,
    output logic           valid,
    input  logic           ready,
    output logic [IN-1:0]  pending,
    output logic           overrun
);
    state_t         state, state_next;
    logic [OUT-1:0] out_next;
    logic [IN-1:0]  arr, sel, clr, rem;
    logic [OUT-1:0] pend_idx, rem_idx;
    logic           pend_any, rem_any, ack;

    assign valid = (state == PRESENT);
    assign ack   = valid && ready;
    assign arr   = enable ? in : '0;
    assign sel   = IN'(1) << out;
    assign clr   = ack ? sel : '0;
    // Same-cycle arrivals are deliberately excluded so out only advances to
    // events that were already pending.
    assign rem   = pending & ~sel;

    pri_enc_8_3 #(.IN(IN), .OUT(OUT)) u_pri_pend (
        .vec (pending),
        .idx (pend_idx),
        .any (pend_any)
    );

    pri_enc_8_3 #(.IN(IN), .OUT(OUT)) u_pri_rem (
        .vec (rem),
        .idx (rem_idx),
        .any (rem_any)
    );

    always_comb begin
        state_next = state;
        out_next   = out;
        case (state)
            IDLE: begin
                if (pend_any) begin
                    out_next   = pend_idx;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (ready) begin
                    if (rem_any) out_next   = rem_idx;
                    else         state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            out     <= '0;
            pending <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            out     <= out_next;
            pending <= (pending & ~clr) | arr;
            if (|(arr & pending & ~clr)) overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_event_encoder_8_3.sv
// Directed bench for event_encoder_8_3 with a cycle model checked every cycle.
module tb_event_encoder_8_3;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] in = 8'h00;
    logic [2:0] out;
    logic       valid;
    logic       ready = 1'b0;
    logic [7:0] pending;
    logic       overrun;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    // Behavioural model: a set of pending event numbers plus the one on offer.
    bit m_pend[8];
    bit m_valid = 1'b0;
    int m_out = 0;
    bit m_ovr = 1'b0;

    event_encoder_8_3 dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .in      (in),
        .out     (out),
        .valid   (valid),
        .ready   (ready),
        .pending (pending),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic int model_pend_word();
        int w = 0;
        for (int i = 0; i < 8; i++) if (m_pend[i]) w += (1 << i);
        return w;
    endfunction

    always @(posedge clk) begin
        bit old[8];
        bit acked;
        int best;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
            m_valid = 1'b0;
            m_out   = 0;
            m_ovr   = 1'b0;
        end else begin
            old   = m_pend;
            acked = m_valid && ready;
            for (int i = 0; i < 8; i++) begin
                bit keep, arrive;
                keep   = old[i] && !(acked && i == m_out);
                arrive = enable && in[i];
                if (arrive && keep) m_ovr = 1'b1;
                m_pend[i] = keep || arrive;
            end
            best = -1;
            for (int i = 0; i < 8; i++)
                if (old[i] && !(m_valid && i == m_out)) best = i;
            if (!m_valid) begin
                if (best >= 0) begin
                    m_out   = best;
                    m_valid = 1'b1;
                end
            end else if (ready) begin
                if (best >= 0) m_out = best;
                else           m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_valid", int'(valid), int'(m_valid));
            check("model_pending", int'(pending), model_pend_word());
            check("model_overrun", int'(overrun), int'(m_ovr));
            if (m_valid) check("model_out", int'(out), m_out);
        end
    end

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        // Reset with all inputs active: nothing may leak in.
        rst = 1'b1; in = 8'hFF; enable = 1'b1; ready = 1'b0;
        cyc(2);
        check("rst_out", int'(out), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_overrun", int'(overrun), 0);
        rst = 1'b0; in = 8'h00;
        chk_on = 1'b1;

        // Single event, immediate accept.
        in = 8'b0000_0010; ready = 1'b1;
        cyc();
        in = 8'h00;
        check("t2_pend_latched", int'(pending), 8'h02);
        check("t2_not_yet_valid", int'(valid), 0);
        cyc();
        check("t2_valid", int'(valid), 1);
        check("t2_out", int'(out), 1);
        cyc();
        check("t2_drained_valid", int'(valid), 0);
        check("t2_drained_pend", int'(pending), 0);

        // Multi-hot drains back-to-back in priority order.
        in = 8'b1010_0001;
        cyc();
        in = 8'h00;
        cyc(); check("t3_out7", int'(out), 7); check("t3_v7", int'(valid), 1);
        cyc(); check("t3_out5", int'(out), 5); check("t3_v5", int'(valid), 1);
        cyc(); check("t3_out0", int'(out), 0); check("t3_v0", int'(valid), 1);
        cyc(); check("t3_idle", int'(valid), 0);
        check("t3_overrun", int'(overrun), 0);

        // Backpressure: presented index holds even when a higher one arrives.
        ready = 1'b0; in = 8'b0000_0100;
        cyc();
        in = 8'b1000_0000;
        cyc();
        in = 8'h00;
        check("t4_out2", int'(out), 2);
        cyc(2);
        check("t4_out2_held", int'(out), 2);
        check("t4_pend", int'(pending), 8'h84);
        ready = 1'b1;
        cyc(); check("t4_out7", int'(out), 7);
        cyc(); check("t4_idle", int'(valid), 0);
        ready = 1'b0;

        // Overrun on a pending, un-acked bit; sticky until reset.
        in = 8'b0000_1000;
        cyc();
        in = 8'h00;
        cyc();
        check("t5_present3", int'(out), 3);
        in = 8'b0000_1000;
        cyc();
        in = 8'h00;
        check("t5_overrun_set", int'(overrun), 1);
        cyc(2);
        check("t5_overrun_sticky", int'(overrun), 1);
        rst = 1'b1; cyc(); rst = 1'b0;
        check("t5_overrun_rst", int'(overrun), 0);
        // Arrival on the bit being acked is a fresh event, not an overrun.
        in = 8'b0000_1000;
        cyc();
        in = 8'h00;
        cyc();
        check("t5b_present3", int'(out), 3);
        ready = 1'b1; in = 8'b0000_1000;
        cyc();
        in = 8'h00;
        check("t5b_pend_kept", int'(pending), 8'h08);
        check("t5b_no_overrun", int'(overrun), 0);
        cyc();
        check("t5b_re_present", int'(valid), 1);
        check("t5b_re_out", int'(out), 3);
        cyc();
        ready = 1'b0;

        // All eight events at once: 7..0 with no loss.
        in = 8'hFF; ready = 1'b1;
        cyc();
        in = 8'h00;
        for (int k = 7; k >= 0; k--) begin
            cyc();
            check("tff_out", int'(out), k);
        end
        cyc();
        check("tff_idle", int'(valid), 0);
        ready = 1'b0;

        // Enable gating, ready while idle, and reset mid-handshake.
        ready = 1'b1; cyc(2); ready = 1'b0;
        check("t6_ready_idle", int'(valid), 0);
        in = 8'b0001_0000;
        cyc();
        enable = 1'b0; in = 8'hFF;
        cyc();
        check("t6_gated_pend", int'(pending), 8'h10);
        check("t6_present4", int'(out), 4);
        cyc();
        check("t6_gated_pend2", int'(pending), 8'h10);
        rst = 1'b1;
        cyc();
        rst = 1'b0; enable = 1'b1; in = 8'h00;
        check("t6_rst_valid", int'(valid), 0);
        check("t6_rst_pend", int'(pending), 0);

        // Mixed traffic with intermittent backpressure, checked by the model.
        for (int k = 0; k < 40; k++) begin
            in     = ((k % 3) == 0) ? 8'(k * 37 + 5) : 8'h00;
            enable = (k % 7) != 3;
            ready  = (k % 4) != 1;
            cyc();
        end
        in = 8'h00; ready = 1'b1;
        cyc(12);
        check("mix_drained", int'(valid), 0);

        chk_on = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
